redirect_unit: RTL and testbench

- Sits directly downstream of the jalr and branch execution units, alongside the ROB.
- Records each mispredict report, with its correct target, against the ROB tag that produced it.
- When the ROB commits that tag, it raises a one-cycle global flush and a fetch redirect to the correct PC, then holds dispatch for a fixed recovery window.
- It is the sole source of the flush signal that the jalr/branch units consume.

---
 rtl/ooo_types.sv | 18 +
 rtl/redirect_table.sv | 53 +++++
 rtl/redirect_unit.sv | 117 +++++++++++
 tb/tb_redirect_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_types.sv
// rtl/ooo_types.sv - shared types for the out-of-order redirect path
package ooo_types;

    // Tag value meaning "no ROB entry"; never captured into the redirect table.
    localparam int unsigned NO_TAG = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
    } redirect_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } redirect_state_t;

endpackage

// File: rtl/redirect_table.sv
// rtl/redirect_table.sv - tag-indexed mispredict target table with commit bypass
module redirect_table
    import ooo_types::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wa_en_i,
    input  logic [TAG_W-1:0] wa_tag_i,
    input  logic [31:0]      wa_target_i,
    input  logic             wb_en_i,
    input  logic [TAG_W-1:0] wb_tag_i,
    input  logic [31:0]      wb_target_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    input  logic             rd_clr_i,
    input  logic             clr_all_i,
    output logic             rd_hit_o,
    output logic [31:0]      rd_target_o
);

    localparam int DEPTH = 1 << TAG_W;

    redirect_entry_t tbl_q [DEPTH];

    // Port a is written last so it wins a same-tag collision; the commit
    // clear comes after both so a capture-and-retire leaves the entry empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else if (clr_all_i) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            if (wb_en_i) tbl_q[wb_tag_i] <= redirect_entry_t'{valid: 1'b1, target: wb_target_i};
            if (wa_en_i) tbl_q[wa_tag_i] <= redirect_entry_t'{valid: 1'b1, target: wa_target_i};
            if (rd_clr_i) tbl_q[rd_tag_i].valid <= 1'b0;
        end
    end

    always_comb begin
        rd_hit_o    = tbl_q[rd_tag_i].valid;
        rd_target_o = tbl_q[rd_tag_i].target;
        if (wb_en_i && (wb_tag_i == rd_tag_i)) begin
            rd_hit_o    = 1'b1;
            rd_target_o = wb_target_i;
        end
        if (wa_en_i && (wa_tag_i == rd_tag_i)) begin
            rd_hit_o    = 1'b1;
            rd_target_o = wa_target_i;
        end
    end

endmodule

// File: rtl/redirect_unit.sv
// rtl/redirect_unit.sv - commit-time flush, fetch redirect and dispatch recovery hold
module redirect_unit
    import ooo_types::*;
#(
    parameter int TAG_W       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jalr_valid,
    input  logic [TAG_W-1:0] jalr_tag,
    input  logic             jalr_correct,
    input  logic [31:0]      jalr_pc_next,
    input  logic             br_valid,
    input  logic [TAG_W-1:0] br_tag,
    input  logic             br_correct,
    input  logic [31:0]      br_pc_next,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             dispatch_hold,
    output logic [31:0]      mispredict_count
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    redirect_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      count_q, count_d;

    logic        live;
    logic        jalr_cap, br_cap, commit_hit;
    logic        tbl_hit;
    logic [31:0] tbl_target;

    // Everything arriving during the flush cycle belongs to squashed work.
    assign live       = (state_q != FLUSH);
    assign jalr_cap   = live && jalr_valid && !jalr_correct && (jalr_tag != TAG_W'(NO_TAG));
    assign br_cap     = live && br_valid && !br_correct && (br_tag != TAG_W'(NO_TAG));
    assign commit_hit = live && commit_valid && tbl_hit;

    redirect_table #(
        .TAG_W(TAG_W)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wa_en_i     (jalr_cap),
        .wa_tag_i    (jalr_tag),
        .wa_target_i (jalr_pc_next),
        .wb_en_i     (br_cap),
        .wb_tag_i    (br_tag),
        .wb_target_i (br_pc_next),
        .rd_tag_i    (commit_tag),
        .rd_clr_i    (live && commit_valid),
        .clr_all_i   (state_q == FLUSH),
        .rd_hit_o    (tbl_hit),
        .rd_target_o (tbl_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (commit_hit) state_d = FLUSH;
            end
            FLUSH: begin
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (commit_hit) begin
                    state_d = FLUSH;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit_hit) begin
            pc_d    = tbl_target;
            count_d = count_q + 32'd1;
        end
    end

    assign flush            = (state_q == FLUSH);
    assign redirect_valid   = (state_q == FLUSH);
    assign redirect_pc      = pc_q;
    assign dispatch_hold    = (state_q == HOLD);
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_redirect_unit.sv
// tb/tb_redirect_unit.sv - self-checking bench for redirect_unit
module tb_redirect_unit;

    localparam int TAG_W    = 3;
    localparam int HOLD     = 2;
    localparam int NTAGS    = 1 << TAG_W;
    localparam int AGE_IDLE = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             jalr_valid, jalr_correct, br_valid, br_correct, commit_valid;
    logic [TAG_W-1:0] jalr_tag, br_tag, commit_tag;
    logic [31:0]      jalr_pc_next, br_pc_next;
    logic             flush, redirect_valid, dispatch_hold;
    logic [31:0]      redirect_pc, mispredict_count;

    always #5 clk = ~clk;

    redirect_unit #(
        .TAG_W       (TAG_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .jalr_valid       (jalr_valid),
        .jalr_tag         (jalr_tag),
        .jalr_correct     (jalr_correct),
        .jalr_pc_next     (jalr_pc_next),
        .br_valid         (br_valid),
        .br_tag           (br_tag),
        .br_correct       (br_correct),
        .br_pc_next       (br_pc_next),
        .commit_valid     (commit_valid),
        .commit_tag       (commit_tag),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .dispatch_hold    (dispatch_hold),
        .mispredict_count (mispredict_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: pending mispredicts keyed by tag, plus cycles elapsed since the last flush.
    bit          m_valid  [NTAGS];
    logic [31:0] m_target [NTAGS];
    int          m_age;
    logic [31:0] m_pc, m_count;

    task automatic model_reset();
        for (int i = 0; i < NTAGS; i++) begin
            m_valid[i]  = 1'b0;
            m_target[i] = '0;
        end
        m_age   = AGE_IDLE;
        m_pc    = '0;
        m_count = '0;
    endtask

    task automatic model_step();
        bit          hit;
        logic [31:0] tgt;
        bit          jm, bm;
        if (m_age == 0) begin
            for (int i = 0; i < NTAGS; i++) m_valid[i] = 1'b0;
            m_age = 1;
        end else begin
            jm  = jalr_valid && !jalr_correct && (jalr_tag != 0);
            bm  = br_valid && !br_correct && (br_tag != 0);
            hit = 1'b0;
            tgt = '0;
            if (commit_valid) begin
                if (jm && jalr_tag == commit_tag) begin hit = 1'b1; tgt = jalr_pc_next; end
                else if (bm && br_tag == commit_tag) begin hit = 1'b1; tgt = br_pc_next; end
                else if (m_valid[commit_tag]) begin hit = 1'b1; tgt = m_target[commit_tag]; end
            end
            if (bm) begin m_valid[br_tag] = 1'b1; m_target[br_tag] = br_pc_next; end
            if (jm) begin m_valid[jalr_tag] = 1'b1; m_target[jalr_tag] = jalr_pc_next; end
            if (commit_valid) m_valid[commit_tag] = 1'b0;
            if (hit) begin
                m_pc    = tgt;
                m_count = m_count + 32'd1;
                m_age   = 0;
            end else if (m_age < AGE_IDLE) begin
                m_age++;
            end
        end
    endtask

    task automatic check_outputs(input string name);
        check_eq({name, ".flush"}, {31'd0, flush}, {31'd0, m_age == 0});
        check_eq({name, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, m_age == 0});
        check_eq({name, ".redirect_pc"}, redirect_pc, m_pc);
        check_eq({name, ".dispatch_hold"}, {31'd0, dispatch_hold}, {31'd0, (m_age >= 1) && (m_age <= HOLD)});
        check_eq({name, ".count"}, mispredict_count, m_count);
    endtask

    task automatic set_idle();
        jalr_valid = 0; jalr_tag = '0; jalr_correct = 0; jalr_pc_next = '0;
        br_valid = 0; br_tag = '0; br_correct = 0; br_pc_next = '0;
        commit_valid = 0; commit_tag = '0;
    endtask

    task automatic cycle(input string name);
        assert (!(jalr_valid && br_valid && jalr_tag == br_tag)) else $error("same-tag reports driven");
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(name);
    endtask

    task automatic idle_cycles(input int n, input string name);
        set_idle();
        for (int i = 0; i < n; i++) cycle(name);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        idle_cycles(1, "post_reset");

        // jalr mispredict then commit two cycles later
        jalr_valid = 1; jalr_tag = 3; jalr_correct = 0; jalr_pc_next = 32'h480;
        cycle("t1.rep");
        idle_cycles(1, "t1.gap");
        commit_valid = 1; commit_tag = 3;
        cycle("t1.commit");
        check_eq("t1.flush", {31'd0, flush}, 32'd1);
        check_eq("t1.pc", redirect_pc, 32'h480);
        check_eq("t1.count", mispredict_count, 32'd1);
        set_idle();
        cycle("t1.h1");
        check_eq("t1.hold1", {31'd0, dispatch_hold}, 32'd1);
        cycle("t1.h2");
        check_eq("t1.hold2", {31'd0, dispatch_hold}, 32'd1);
        cycle("t1.end");
        check_eq("t1.hold_end", {31'd0, dispatch_hold}, 32'd0);

        // correctly predicted jalr
        jalr_valid = 1; jalr_tag = 5; jalr_correct = 1; jalr_pc_next = 32'h999;
        cycle("t2.rep");
        set_idle();
        commit_valid = 1; commit_tag = 5;
        cycle("t2.commit");
        check_eq("t2.flush", {31'd0, flush}, 32'd0);
        check_eq("t2.count", mispredict_count, 32'd1);
        idle_cycles(1, "t2.idle");

        // capture and commit in the same cycle
        br_valid = 1; br_tag = 2; br_correct = 0; br_pc_next = 32'h100;
        commit_valid = 1; commit_tag = 2;
        cycle("t3.commit");
        check_eq("t3.flush", {31'd0, flush}, 32'd1);
        check_eq("t3.pc", redirect_pc, 32'h100);
        idle_cycles(3, "t3.idle");

        // simultaneous reports; first flush wipes the second
        jalr_valid = 1; jalr_tag = 1; jalr_correct = 0; jalr_pc_next = 32'h200;
        br_valid = 1; br_tag = 4; br_correct = 0; br_pc_next = 32'h300;
        cycle("t4.rep");
        set_idle();
        commit_valid = 1; commit_tag = 1;
        cycle("t4.c1");
        check_eq("t4.pc", redirect_pc, 32'h200);
        idle_cycles(3, "t4.idle");
        commit_valid = 1; commit_tag = 4;
        cycle("t4.c4");
        check_eq("t4.noflush", {31'd0, flush}, 32'd0);
        idle_cycles(1, "t4.idle2");

        // report arriving during the flush cycle is dropped
        jalr_valid = 1; jalr_tag = 7; jalr_correct = 0; jalr_pc_next = 32'h700;
        commit_valid = 1; commit_tag = 7;
        cycle("t5.commit");
        set_idle();
        jalr_valid = 1; jalr_tag = 6; jalr_correct = 0; jalr_pc_next = 32'h600;
        cycle("t5.inflush");
        idle_cycles(2, "t5.idle");
        commit_valid = 1; commit_tag = 6;
        cycle("t5.c6");
        check_eq("t5.noflush", {31'd0, flush}, 32'd0);
        idle_cycles(1, "t5.idle2");

        // build count up to 7, reset mid-HOLD with tag 5 pending
        while (m_count < 6) begin
            br_valid = 1; br_tag = 1; br_correct = 0; br_pc_next = 32'h1000 + m_count;
            commit_valid = 1; commit_tag = 1;
            cycle("t6.build");
            idle_cycles(3, "t6.idle");
        end
        jalr_valid = 1; jalr_tag = 3; jalr_correct = 0; jalr_pc_next = 32'h3300;
        commit_valid = 1; commit_tag = 3;
        cycle("t6.seventh");
        idle_cycles(1, "t6.h1");
        jalr_valid = 1; jalr_tag = 5; jalr_correct = 0; jalr_pc_next = 32'h555;
        cycle("t6.cap5");
        check_eq("t6.count7", mispredict_count, 32'd7);
        check_eq("t6.inhold", {31'd0, dispatch_hold}, 32'd1);
        set_idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6.rst_flush", {31'd0, flush}, 32'd0);
        check_eq("t6.rst_rv", {31'd0, redirect_valid}, 32'd0);
        check_eq("t6.rst_hold", {31'd0, dispatch_hold}, 32'd0);
        check_eq("t6.rst_count", mispredict_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        commit_valid = 1; commit_tag = 5;
        cycle("t6.c5");
        check_eq("t6.noflush", {31'd0, flush}, 32'd0);
        idle_cycles(1, "t6.idle");

        // randomized traffic against the reference
        for (int n = 0; n < 1500; n++) begin
            jalr_valid   = ($urandom_range(0, 2) == 0);
            jalr_tag     = TAG_W'($urandom_range(0, NTAGS - 1));
            jalr_correct = ($urandom_range(0, 3) == 0);
            jalr_pc_next = $urandom;
            br_valid     = ($urandom_range(0, 2) == 0);
            br_tag       = TAG_W'($urandom_range(0, NTAGS - 1));
            br_correct   = ($urandom_range(0, 3) == 0);
            br_pc_next   = $urandom;
            if (jalr_valid && br_valid && jalr_tag == br_tag)
                br_tag = jalr_tag ^ TAG_W'($urandom_range(1, NTAGS - 1));
            commit_valid = ($urandom_range(0, 2) == 0);
            commit_tag   = TAG_W'($urandom_range(0, NTAGS - 1));
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
